clk_gate_ctrl: RTL and testbench

Enable controller that drives the CLK_EN input of the integrated clock-gating cell in front of a gated clock domain (e.g. the ALU). It wakes the gated clock on a client request and waits a settle interval before acknowledging. It keeps the clock running while the domain is busy, and shuts the clock off only after a programmable run of idle cycles. All outputs are flop-driven so CLK_EN changes only on the CLK rising edge, as the downstream gating latch requires.

---
 rtl/clk_gate_ctrl.sv | 112 +++++++++++
 tb/tb_clk_gate_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Enable controller for the integrated clock-gating cell of a gated domain.
// Wakes the gated clock on demand, waits a settle interval before ACK,
// keeps it running while the domain is busy and drops it after a run of
// idle cycles. Outputs are flops so CLK_EN only moves on the CLK rising edge.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_OFF  | gated clock disabled, waiting for a wake source
//   S_WAKE | CLK_EN high, counting settle cycles before ACK
//   S_ON   | gated clock running and stable, ACK high
//   S_HOLD | clock still running, counting idle cycles before shutdown
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ,
  input  logic BUSY,
  input  logic FORCE_ON,
  output logic CLK_EN,
  output logic ACK,
  output logic CLK_OFF
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WAKE_LOAD = CNT_WIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] IDLE_LOAD = CNT_WIDTH'(IDLE_CYCLES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 wake;

  // Any of the three sources keeps or brings the gated clock up.
  assign wake = REQ | BUSY | FORCE_ON;

  // State, shared down-counter and outputs; outputs are set alongside the
  // state they decode from, so they always match the registered state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_OFF;
      cnt     <= '0;
      CLK_EN  <= 1'b0;
      ACK     <= 1'b0;
      CLK_OFF <= 1'b1;
    end else begin
      case (state)
        S_OFF: begin
          if (wake) begin
            state   <= S_WAKE;
            cnt     <= WAKE_LOAD;
            CLK_EN  <= 1'b1;
            ACK     <= 1'b0;
            CLK_OFF <= 1'b0;
          end
        end
        // Settle interval always runs to completion, even if wake drops.
        S_WAKE: begin
          if (cnt == '0) begin
            state   <= S_ON;
            CLK_EN  <= 1'b1;
            ACK     <= 1'b1;
            CLK_OFF <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ON: begin
          if (!wake) begin
            state   <= S_HOLD;
            cnt     <= IDLE_LOAD;
            CLK_EN  <= 1'b1;
            ACK     <= 1'b0;
            CLK_OFF <= 1'b0;
          end
        end
        // A returning wake beats counter expiry; the clock never blinked,
        // so no settle interval is needed.
        S_HOLD: begin
          if (wake) begin
            state   <= S_ON;
            CLK_EN  <= 1'b1;
            ACK     <= 1'b1;
            CLK_OFF <= 1'b0;
          end else if (cnt == '0) begin
            state   <= S_OFF;
            CLK_EN  <= 1'b0;
            ACK     <= 1'b0;
            CLK_OFF <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= S_OFF;
          cnt     <= '0;
          CLK_EN  <= 1'b0;
          ACK     <= 1'b0;
          CLK_OFF <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl (WAKE_CYCLES=2, IDLE_CYCLES=4).
// Stimulus pushes the hand-computed output triple expected after the next
// rising edge; a monitor pops and compares on the following falling edge.
module tb_clk_gate_ctrl;

  logic CLK = 1'b0;
  logic RST;
  logic REQ;
  logic BUSY;
  logic FORCE_ON;
  logic CLK_EN;
  logic ACK;
  logic CLK_OFF;

  typedef struct {
    int    tag;
    logic  en;
    logic  ack;
    logic  off;
    string name;
  } exp_t;

  exp_t exp_q[$];
  exp_t imm_q[$];
  event imm_ev;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  clk_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2),
    .CNT_WIDTH  (4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .BUSY    (BUSY),
    .FORCE_ON(FORCE_ON),
    .CLK_EN  (CLK_EN),
    .ACK     (ACK),
    .CLK_OFF (CLK_OFF)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic compare(input exp_t e);
    n_checks++;
    if (CLK_EN === e.en && ACK === e.ack && CLK_OFF === e.off) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: en/ack/off got %b%b%b expected %b%b%b",
               e.name, $time, CLK_EN, ACK, CLK_OFF, e.en, e.ack, e.off);
    end
  endtask

  // Edge-aligned monitor: entries are due at the falling edge of their cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
        e = exp_q.pop_front();
        if (e.tag < cyc) begin
          n_checks++;
          $display("FAIL %s: stale entry, tag %0d but cycle %0d", e.name, e.tag, cyc);
        end else begin
          compare(e);
        end
      end
    end
  end

  // Asynchronous monitor: checks outputs between clock edges.
  initial begin
    forever begin
      @(imm_ev);
      while (imm_q.size() > 0) compare(imm_q.pop_front());
    end
  end

  // Apply inputs at a falling edge; expected outputs follow the next rising edge.
  task automatic step(input logic r, input logic q, input logic b, input logic f,
                      input logic e_en, input logic e_ack, input logic e_off,
                      input string nm);
    exp_t e;
    RST = r; REQ = q; BUSY = b; FORCE_ON = f;
    e.tag = cyc + 1; e.en = e_en; e.ack = e_ack; e.off = e_off; e.name = nm;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  initial begin
    exp_t e;
    RST = 1'b0; REQ = 1'b1; BUSY = 1'b0; FORCE_ON = 1'b0;
    @(negedge CLK);

    // 1: reset held with REQ high, then release and wake
    repeat (3) step(0, 1, 0, 0, 0, 0, 1, "rst_hold");
    step(1, 1, 0, 0, 1, 0, 0, "wake_edge0");
    step(1, 1, 0, 0, 1, 0, 0, "wake_edge1");
    step(1, 1, 0, 0, 1, 1, 0, "ack_edge2");

    // 2: idle from ON drops the clock after 4 edges
    step(1, 0, 0, 0, 1, 0, 0, "hold_enter");
    repeat (3) step(1, 0, 0, 0, 1, 0, 0, "hold_keep_en");
    step(1, 0, 0, 0, 0, 0, 1, "idle_off");
    step(1, 0, 0, 0, 0, 0, 1, "stay_off");

    // 3: wake returns in the 3rd HOLD cycle, straight back to ON
    step(1, 1, 0, 0, 1, 0, 0, "t3_wake");
    step(1, 1, 0, 0, 1, 0, 0, "t3_wake2");
    step(1, 1, 0, 0, 1, 1, 0, "t3_on");
    step(1, 0, 0, 0, 1, 0, 0, "t3_hold1");
    step(1, 0, 0, 0, 1, 0, 0, "t3_hold2");
    step(1, 0, 0, 0, 1, 0, 0, "t3_hold3");
    step(1, 1, 0, 0, 1, 1, 0, "t3_rewake_on");
    step(1, 1, 0, 0, 1, 1, 0, "t3_stay_on");

    // 4: BUSY alone holds ON, then normal idle shutdown
    repeat (10) step(1, 0, 1, 0, 1, 1, 0, "busy_on");
    step(1, 0, 0, 0, 1, 0, 0, "busy_hold");
    repeat (3) step(1, 0, 0, 0, 1, 0, 0, "busy_hold_en");
    step(1, 0, 0, 0, 0, 0, 1, "busy_off");

    // wake at counter expiry wins over shutdown
    step(1, 1, 0, 0, 1, 0, 0, "prio_wake");
    step(1, 1, 0, 0, 1, 0, 0, "prio_wake2");
    step(1, 1, 0, 0, 1, 1, 0, "prio_on");
    step(1, 0, 0, 0, 1, 0, 0, "prio_hold");
    repeat (3) step(1, 0, 0, 0, 1, 0, 0, "prio_hold_en");
    step(1, 0, 1, 0, 1, 1, 0, "prio_expiry_on");
    step(1, 0, 0, 0, 1, 0, 0, "prio_hold_b");
    repeat (3) step(1, 0, 0, 0, 1, 0, 0, "prio_hold_b_en");
    step(1, 0, 0, 0, 0, 0, 1, "prio_off");

    // 5: FORCE_ON right after OFF entry goes through WAKE again
    step(1, 0, 0, 1, 1, 0, 0, "force_wake");
    step(1, 0, 0, 1, 1, 0, 0, "force_wake2");
    repeat (8) step(1, 0, 0, 1, 1, 1, 0, "force_on");
    step(1, 0, 0, 0, 1, 0, 0, "force_hold");
    repeat (3) step(1, 0, 0, 0, 1, 0, 0, "force_hold_en");
    step(1, 0, 0, 0, 0, 0, 1, "force_off");

    // 6: asynchronous reset in the middle of WAKE
    step(1, 1, 0, 0, 1, 0, 0, "t6_wake");
    #2 RST = 1'b0;
    #1;
    e.tag = 0; e.en = 1'b0; e.ack = 1'b0; e.off = 1'b1; e.name = "async_rst";
    imm_q.push_back(e);
    ->imm_ev;
    @(negedge CLK);
    step(0, 1, 0, 0, 0, 0, 1, "t6_rst_held");
    step(1, 1, 0, 0, 1, 0, 0, "t6_rewake1");
    step(1, 1, 0, 0, 1, 0, 0, "t6_rewake2");
    step(1, 1, 0, 0, 1, 1, 0, "t6_ack");

    for (int i = 0; i < 5 && (exp_q.size() > 0 || imm_q.size() > 0); i++) @(negedge CLK);
    if (exp_q.size() > 0 || imm_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size() + imm_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
